// File: rtl/mips_pkg.sv
// Shared encodings for the 8-bit multicycle MIPS subset core:
// opcodes, funct codes, ALU control and controller state.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_SB    = 6'h28;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  } alufn_e;

  typedef enum logic [1:0] {
    SRCB_REG, SRCB_ONE, SRCB_IMM, SRCB_IMMX4
  } srcb_e;

  typedef enum logic [1:0] {
    PC_ALU, PC_ALUOUT, PC_JUMP
  } pcsrc_e;

  typedef enum logic [3:0] {
    FETCH1, FETCH2, FETCH3, FETCH4, DECODE, MEMADR, LBRD, LBWR, SBWR,
    RTYPEEX, RTYPEWR, BEQEX, JEX, ADDIEX, ADDIWR
  } state_e;

endpackage

// File: rtl/mips_regfile.sv
// Register file: two combinational read ports, one clocked write port,
// register 0 hard-wired to zero.
module mips_regfile #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned REGBITS = 3
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [REGBITS-1:0] ra1_i,
  input  logic [REGBITS-1:0] ra2_i,
  input  logic [REGBITS-1:0] wa_i,
  input  logic [WIDTH-1:0]   wd_i,
  output logic [WIDTH-1:0]   rd1_o,
  output logic [WIDTH-1:0]   rd2_o
);

  localparam int unsigned NREGS = 2 ** REGBITS;

  logic [WIDTH-1:0] regs_q [NREGS];

  always_ff @(posedge clk) begin
    if (we_i && (wa_i != '0)) regs_q[wa_i] <= wd_i;
  end

  assign rd1_o = (ra1_i == '0) ? '0 : regs_q[ra1_i];
  assign rd2_o = (ra2_i == '0) ? '0 : regs_q[ra2_i];

endmodule

// File: rtl/mips_cpu.sv
// 8-bit multicycle MIPS subset core: byte-serial instruction fetch,
// one shared ALU, controller FSM and datapath muxes inline.
module mips_cpu
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned REGBITS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] memdata,
  output logic             memread,
  output logic             memwrite,
  output logic [WIDTH-1:0] adr,
  output logic [WIDTH-1:0] writedata
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic [WIDTH-1:0] a_q, b_q, mdr_q, aluout_q;

  logic             mem_we, iord, pc_we, pc_branch, pc_en, alusrca;
  logic             reg_we, regdst, memtoreg;
  logic [3:0]       ir_byte_en;
  srcb_e            alusrcb;
  aluop_e           aluop;
  pcsrc_e           pc_src;
  alufn_e           alufn;

  logic [5:0]         op, funct;
  logic [REGBITS-1:0] rs, rt, rd;
  logic [WIDTH-1:0]   imm, immx4, rd1, rd2, src_a, src_b, diff, alu_res, wd;
  logic               alu_zero, unused_ir;

  assign op        = ir_q[31:26];
  assign funct     = ir_q[5:0];
  assign rs        = ir_q[21 +: REGBITS];
  assign rt        = ir_q[16 +: REGBITS];
  assign rd        = ir_q[11 +: REGBITS];
  assign imm       = ir_q[WIDTH-1:0];
  assign immx4     = {ir_q[WIDTH-3:0], 2'b00};
  assign unused_ir = ^ir_q;

  // Controller: one state per cycle
  always_comb begin
    state_d    = FETCH1;
    memread    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_byte_en = 4'b0000;
    pc_we      = 1'b0;
    pc_branch  = 1'b0;
    pc_src     = PC_ALU;
    alusrca    = 1'b0;
    alusrcb    = SRCB_REG;
    aluop      = ALUOP_ADD;
    reg_we     = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    case (state_q)
      FETCH1: begin memread = 1'b1; ir_byte_en = 4'b1000; pc_we = 1'b1; alusrcb = SRCB_ONE; state_d = FETCH2; end
      FETCH2: begin memread = 1'b1; ir_byte_en = 4'b0100; pc_we = 1'b1; alusrcb = SRCB_ONE; state_d = FETCH3; end
      FETCH3: begin memread = 1'b1; ir_byte_en = 4'b0010; pc_we = 1'b1; alusrcb = SRCB_ONE; state_d = FETCH4; end
      FETCH4: begin memread = 1'b1; ir_byte_en = 4'b0001; pc_we = 1'b1; alusrcb = SRCB_ONE; state_d = DECODE; end
      DECODE: begin
        alusrcb = SRCB_IMMX4;
        case (op)
          OP_LB, OP_SB: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_J:         state_d = JEX;
          OP_ADDI:      state_d = ADDIEX;
          default:      state_d = FETCH1;
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_d = (op == OP_SB) ? SBWR : LBRD;
      end
      LBRD:    begin memread = 1'b1; iord = 1'b1; state_d = LBWR; end
      LBWR:    begin reg_we = 1'b1; memtoreg = 1'b1; end
      SBWR:    begin iord = 1'b1; mem_we = 1'b1; end
      RTYPEEX: begin alusrca = 1'b1; aluop = ALUOP_FUNCT; state_d = RTYPEWR; end
      RTYPEWR: begin reg_we = 1'b1; regdst = 1'b1; end
      BEQEX:   begin alusrca = 1'b1; aluop = ALUOP_SUB; pc_branch = 1'b1; pc_src = PC_ALUOUT; end
      JEX:     begin pc_we = 1'b1; pc_src = PC_JUMP; end
      ADDIEX:  begin alusrca = 1'b1; alusrcb = SRCB_IMM; state_d = ADDIWR; end
      ADDIWR:  begin reg_we = 1'b1; end
      default: state_d = FETCH1;
    endcase
  end

  // ALU control and shared ALU
  always_comb begin
    alufn = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alufn = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_SUB:  alufn = ALU_SUB;
          FN_AND:  alufn = ALU_AND;
          FN_OR:   alufn = ALU_OR;
          FN_SLT:  alufn = ALU_SLT;
          default: alufn = ALU_ADD;
        endcase
      end
      default: alufn = ALU_ADD;
    endcase
  end

  assign src_a = alusrca ? a_q : pc_q;

  always_comb begin
    case (alusrcb)
      SRCB_ONE:   src_b = WIDTH'(1);
      SRCB_IMM:   src_b = imm;
      SRCB_IMMX4: src_b = immx4;
      default:    src_b = b_q;
    endcase
  end

  assign diff = src_a - src_b;

  always_comb begin
    case (alufn)
      ALU_SUB: alu_res = diff;
      ALU_AND: alu_res = src_a & src_b;
      ALU_OR:  alu_res = src_a | src_b;
      ALU_SLT: alu_res = WIDTH'(diff[WIDTH-1]);
      default: alu_res = src_a + src_b;
    endcase
  end

  assign alu_zero = (alu_res == '0);
  assign pc_en    = pc_we | (pc_branch & alu_zero);

  always_comb begin
    pc_d = pc_q;
    if (pc_en) begin
      case (pc_src)
        PC_ALUOUT: pc_d = aluout_q;
        PC_JUMP:   pc_d = immx4;
        default:   pc_d = alu_res;
      endcase
    end
  end

  always_comb begin
    ir_d = ir_q;
    if (ir_byte_en[3]) ir_d[31:24] = memdata;
    if (ir_byte_en[2]) ir_d[23:16] = memdata;
    if (ir_byte_en[1]) ir_d[15:8]  = memdata;
    if (ir_byte_en[0]) ir_d[7:0]   = memdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH1;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Datapath holding registers reload every cycle
  always_ff @(posedge clk) begin
    a_q      <= rd1;
    b_q      <= rd2;
    mdr_q    <= memdata;
    aluout_q <= alu_res;
  end

  assign wd = memtoreg ? mdr_q : aluout_q;

  mips_regfile #(.WIDTH(WIDTH), .REGBITS(REGBITS)) u_regfile (
    .clk   (clk),
    .we_i  (reg_we & ~reset),
    .ra1_i (rs),
    .ra2_i (rt),
    .wa_i  (regdst ? rd : rt),
    .wd_i  (wd),
    .rd1_o (rd1),
    .rd2_o (rd2)
  );

  assign memwrite  = mem_we & ~reset;
  assign adr       = iord ? aluout_q : pc_q;
  assign writedata = b_q;

endmodule

// File: tb/tb_mips_cpu.sv
// Self-checking bench for mips_cpu: table of R-type programs plus directed
// sequences for reset, fibonacci, beq, j/r0, lb/sb and reset during LBRD.
module tb_mips_cpu;

  logic       clk;
  logic       reset;
  logic [7:0] memdata, adr, writedata;
  logic       memread, memwrite;

  logic [7:0] mem [256];

  int unsigned n_pass = 0;
  int unsigned n_tot  = 0;

  int unsigned cyc;
  int unsigned st_n;
  logic [7:0]  st_adr [4];
  logic [7:0]  st_dat [4];
  int unsigned st_cyc [4];

  mips_cpu #(.WIDTH(8), .REGBITS(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .memdata   (memdata),
    .memread   (memread),
    .memwrite  (memwrite),
    .adr       (adr),
    .writedata (writedata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign memdata = mem[adr];

  // Store log; st_cyc is the 1-based cycle number after reset release
  always @(posedge clk) begin
    if (reset) begin
      cyc  <= 0;
      st_n <= 0;
    end else begin
      cyc <= cyc + 1;
      if (memwrite) begin
        if (st_n < 4) begin
          st_adr[st_n[1:0]] <= adr;
          st_dat[st_n[1:0]] <= writedata;
          st_cyc[st_n[1:0]] <= cyc + 1;
        end
        st_n <= st_n + 1;
      end
    end
  end

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] funct;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic put_word(input logic [7:0] a, input logic [31:0] w);
    mem[a]        = w[31:24];
    mem[a + 8'd1] = w[23:16];
    mem[a + 8'd2] = w[15:8];
    mem[a + 8'd3] = w[7:0];
  endtask

  task automatic hold_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Leaves the caller at the sample point of cycle 1
  task automatic release_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_stores(input string name, input int unsigned n, input int unsigned budget);
    int unsigned i;
    i = 0;
    while (st_n < n && i < budget) begin
      @(negedge clk);
      i++;
    end
    check({name, " store seen"}, (st_n >= n) ? 1 : 0, 1);
  endtask

  initial begin
    reset = 1'b1;

    vecs[0] = '{"add",      8'h05, 8'h08, 6'h20, 8'h0D};
    vecs[1] = '{"sub",      8'h05, 8'h08, 6'h22, 8'hFD};
    vecs[2] = '{"and",      8'h0C, 8'h0A, 6'h24, 8'h08};
    vecs[3] = '{"or",       8'h0C, 8'h0A, 6'h25, 8'h0E};
    vecs[4] = '{"slt 3,5",  8'h03, 8'h05, 6'h2A, 8'h01};
    vecs[5] = '{"slt 5,3",  8'h05, 8'h03, 6'h2A, 8'h00};
    vecs[6] = '{"slt 1,80", 8'h01, 8'h80, 6'h2A, 8'h01};
    vecs[7] = '{"slt 80,1", 8'h80, 8'h01, 6'h2A, 8'h00};
    vecs[8] = '{"funct 00", 8'h02, 8'h03, 6'h00, 8'h05};
    vecs[9] = '{"add wrap", 8'hFF, 8'h02, 6'h20, 8'h01};

    // Reset state, fetch address stepping, then the addi/add/sb program
    clear_mem();
    put_word(8'd0,  32'h20010005);
    put_word(8'd4,  32'h20020008);
    put_word(8'd8,  32'h00221820);
    put_word(8'd12, 32'hA00300FF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset adr", adr, 0);
    check("reset memread", memread, 1);
    check("reset memwrite", memwrite, 0);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("fetch adr cycle %0d", k + 1), adr, k);
      check($sformatf("fetch memread cycle %0d", k + 1), memread, 1);
      @(negedge clk);
    end
    wait_stores("prog1", 1, 100);
    check("prog1 adr", st_adr[0], 8'hFF);
    check("prog1 data", st_dat[0], 8'd13);
    check("prog1 cycle", st_cyc[0], 28);

    // R-type table: r1=a, r2=b, r3=r1 funct r2, store r3 at 0xFF
    for (int v = 0; v < 10; v++) begin
      hold_reset();
      clear_mem();
      put_word(8'd0,  32'h20010000 | 32'(vecs[v].a));
      put_word(8'd4,  32'h20020000 | 32'(vecs[v].b));
      put_word(8'd8,  32'h00221800 | 32'(vecs[v].funct));
      put_word(8'd12, 32'hA00300FF);
      release_reset();
      wait_stores(vecs[v].name, 1, 100);
      check({vecs[v].name, " adr"},   st_adr[0], 8'hFF);
      check({vecs[v].name, " data"},  st_dat[0], vecs[v].exp);
      check({vecs[v].name, " cycle"}, st_cyc[0], 28);
    end

    // Fibonacci: first and only early store is 13 at 0xFF
    hold_reset();
    clear_mem();
    put_word(8'd0,  32'h20030008);
    put_word(8'd4,  32'h20040001);
    put_word(8'd8,  32'h2005FFFF);
    put_word(8'd12, 32'h10600004);
    put_word(8'd16, 32'h00852020);
    put_word(8'd20, 32'h00852822);
    put_word(8'd24, 32'h2063FFFF);
    put_word(8'd28, 32'h08000003);
    put_word(8'd32, 32'hA00400FF);
    release_reset();
    wait_stores("fib", 1, 1000);
    check("fib adr", st_adr[0], 8'hFF);
    check("fib data", st_dat[0], 8'd13);
    check("fib cycle", st_cyc[0], 298);

    // beq taken skips one instruction, beq not taken falls through
    hold_reset();
    clear_mem();
    put_word(8'd0,  32'h20010003);
    put_word(8'd4,  32'h20020003);
    put_word(8'd8,  32'h20040001);
    put_word(8'd12, 32'h10220001);
    put_word(8'd16, 32'h20040007);
    put_word(8'd20, 32'hA00400F0);
    put_word(8'd24, 32'h10240001);
    put_word(8'd28, 32'hA00200F1);
    release_reset();
    wait_stores("beq", 2, 200);
    check("beq taken adr",  st_adr[0], 8'hF0);
    check("beq taken data", st_dat[0], 8'd1);
    check("beq taken cycle", st_cyc[0], 34);
    check("beq fall adr",   st_adr[1], 8'hF1);
    check("beq fall data",  st_dat[1], 8'd3);
    check("beq fall cycle", st_cyc[1], 47);

    // Write to r0 is ignored; j 0 loops back to the start
    hold_reset();
    clear_mem();
    put_word(8'd0, 32'h20000009);
    put_word(8'd4, 32'hA00000F2);
    put_word(8'd8, 32'h08000000);
    release_reset();
    wait_stores("j/r0", 2, 200);
    check("r0 data", st_dat[0], 8'd0);
    check("r0 cycle", st_cyc[0], 14);
    check("j loop adr", st_adr[1], 8'hF2);
    check("j loop cycle", st_cyc[1], 34);

    // lb then sb of the loaded byte
    hold_reset();
    clear_mem();
    put_word(8'd0, 32'h80010080);
    put_word(8'd4, 32'hA00100F3);
    mem[8'h80] = 8'hA5;
    release_reset();
    wait_stores("lb/sb", 1, 100);
    check("lb/sb adr", st_adr[0], 8'hF3);
    check("lb/sb data", st_dat[0], 8'hA5);
    check("lb/sb cycle", st_cyc[0], 15);

    // Reset during LBRD must not write r1; restart runs nops then stores r1
    hold_reset();
    clear_mem();
    put_word(8'd0, 32'h20010011);
    put_word(8'd4, 32'h80010080);
    put_word(8'd8, 32'hA00100F4);
    mem[8'h80] = 8'h5A;
    release_reset();
    repeat (13) @(negedge clk);
    check("lbrd adr", adr, 8'h80);
    check("lbrd memread", memread, 1);
    reset = 1'b1;
    put_word(8'd0, 32'hFC000000);
    put_word(8'd4, 32'hFC000000);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("restart adr", adr, 0);
    check("restart memwrite", memwrite, 0);
    wait_stores("abort", 1, 100);
    check("abort adr", st_adr[0], 8'hF4);
    check("abort data", st_dat[0], 8'h11);
    check("abort cycle", st_cyc[0], 17);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/mips_cpu.md
Name: mips_cpu

Overview:
- 8-bit multicycle subset-MIPS core: fetches 32-bit instructions one byte per cycle over a byte-wide memory port.
- Executes lb, sb, add, sub, and, or, slt, beq, j, addi through a single shared ALU.
- Sits between the testbench clock/reset and an external byte-addressed memory with combinational reads and clocked writes.

Parameters:
- WIDTH, 8, datapath, PC, address and memory-data width in bits.
- REGBITS, 3, register-index width; the register file holds 2**REGBITS registers.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- memdata  input  WIDTH  byte read from memory at adr; combinational.
- memread  output  1  asserted in the FETCH1-4 and LBRD states.
- memwrite  output  1  asserted only in SBWR; memory writes writedata at the next rising edge.
- adr  output  WIDTH  memory address: PC when iord=0, ALUOut when iord=1.
- writedata  output  WIDTH  B register (latched rt value), valid during SBWR.

Behaviour:
- Reset (synchronous): PC=0, state=FETCH1, IR=0.
  - Outputs in reset state: memread=1, memwrite=0, adr=0.
  - Register file contents are not reset.
  - Reset asserted in any state aborts the instruction; no register or memory write occurs on that edge.
- Internal registers: PC, IR[31:0], A (rd1), B (rd2), MDR, ALUOut.
  - A, B, MDR and ALUOut load every cycle.
- Instruction fields:
  - op = IR[31:26], funct = IR[5:0].
  - rs = IR[21+REGBITS-1:21], rt = IR[16+REGBITS-1:16], rd = IR[11+REGBITS-1:11].
  - imm = IR[WIDTH-1:0], used unsigned with no sign extension.
  - immx4 = {IR[WIDTH-3:0], 2'b00}.
- Register file: register 0 reads 0 and ignores writes; 2 combinational read ports, 1 write port on the rising edge.
- ALU: add, sub, and, or, slt; all WIDTH-bit, wrapping.
  - slt result = MSB of (a-b), zero-extended.
  - zero flag = (result == 0).
- ALU control: aluop 00 = add, 01 = sub, 10 = decode funct.
  - funct codes: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt.
  - Any other funct executes as add.
- FSM (one state per cycle):
  - FETCH1..FETCH4: adr=PC, memread=1; IR byte k loads memdata (FETCH1 fills IR[31:24] … FETCH4 fills IR[7:0]); PC <= PC+1. Next state is the following FETCH, FETCH4 -> DECODE.
  - DECODE: ALUOut <= PC + immx4 (branch target); A/B latch rs/rt.
    - op 0x20 or 0x28 -> MEMADR; 0x00 -> RTYPEEX; 0x04 -> BEQEX; 0x02 -> JEX; 0x08 -> ADDIEX.
    - Any other op -> FETCH1 (treated as nop).
  - MEMADR: ALUOut <= A + imm; op lb -> LBRD, op sb -> SBWR.
  - LBRD: adr=ALUOut, memread=1, MDR <= memdata; -> LBWR.
  - LBWR: reg[rt] <= MDR; -> FETCH1.
  - SBWR: adr=ALUOut, memwrite=1, writedata=B; -> FETCH1.
  - RTYPEEX: ALUOut <= A funct B; -> RTYPEWR.
  - RTYPEWR: reg[rd] <= ALUOut; -> FETCH1.
  - BEQEX: compute A-B; if zero, PC <= ALUOut (DECODE target); -> FETCH1.
  - JEX: PC <= immx4; -> FETCH1.
  - ADDIEX: ALUOut <= A + imm; -> ADDIWR.
  - ADDIWR: reg[rt] <= ALUOut; -> FETCH1.
- Latency in cycles: lb 8, sb 7, R-type 7, addi 7, beq 6, j 6.
- PC wraps modulo 2**WIDTH.
- memwrite is never asserted outside SBWR.

Decomposition:
- Package mips_pkg holds:
  - opcode constants (LB, SB, RTYPE, BEQ, J, ADDI);
  - funct constants;
  - aluop encodings;
  - FSM state enum.
- Natural sub-module: mips_regfile (parameterised WIDTH/REGBITS, r0 hard-wired to zero).
- Controller FSM, ALU and datapath muxes stay inline in mips_cpu.

Test Plan:
- Reset: hold reset 2 cycles -> adr=0, memread=1, memwrite=0; after release, adr steps 0,1,2,3 over the first four cycles.
- addi/add/sb program:
  - Program: 0x20010005, 0x20020008, 0x00221820, 0xA00300FF.
  - Required: memwrite=1 with adr=255, writedata=13, first asserted in cycle 28 after reset release.
- Fibonacci program -> single store of 13 at address 255 well within 1000 cycles; memwrite never asserted earlier.
- beq:
  - Equal operands with offset 1 -> PC skips next instruction.
  - Unequal operands -> falls through; beq completes in 6 cycles.
- j 0x00 loop and slt:
  - slt of 3,5 -> 1; slt of 5,3 -> 0.
  - Write to r0 leaves it reading 0.
- lb then sb of the loaded byte -> stored value equals memory byte.
  - Reset asserted mid-LBRD -> no register write; restart at PC=0.
